// File: rtl/bcd_7seg_scan_driver.sv
// Multiplexed common-anode 7-segment driver with per-digit blanking and frame-synchronous content update.
// Optional build macro LEADING_ZERO_BLANK_EN suppresses zeros above the most significant nonzero digit.
module bcd_7seg_scan_driver #(
  parameter int unsigned N_DIGITS     = 4,
  parameter int unsigned REFRESH_DIV  = 50000,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic [4*N_DIGITS-1:0]   bcd_in,
  output logic                    load_ack,
  output logic [6:0]              seg_n,
  output logic [N_DIGITS-1:0]     digit_en_n,
  output logic                    frame_start
);

  localparam int unsigned T_MAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
  localparam int unsigned T_W   = (T_MAX > 1) ? $clog2(T_MAX + 1) : 1;
  localparam int unsigned IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  localparam logic [T_W-1:0]   ON_LAST    = T_W'(REFRESH_DIV - 1);
  localparam logic [T_W-1:0]   BLANK_LAST = T_W'((BLANK_CYCLES == 0) ? 0 : BLANK_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(N_DIGITS - 1);

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_ON    = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [T_W-1:0]          timer_q, timer_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [4*N_DIGITS-1:0]   hold_q;
  logic [4*N_DIGITS-1:0]   frame_q, frame_d;
  logic                    fs_q, fs_d;
  logic                    ack_q;
  logic [6:0]              seg_q, seg_d;
  logic [N_DIGITS-1:0]     en_q, en_d;
  logic [3:0]              nib;
  logic [N_DIGITS-1:0]     lz_blank;

  function automatic logic [6:0] seg_mask(input logic [3:0] d);
    logic [6:0] m;
    case (d)
      4'd0:    m = 7'h3F;
      4'd1:    m = 7'h06;
      4'd2:    m = 7'h5B;
      4'd3:    m = 7'h4F;
      4'd4:    m = 7'h66;
      4'd5:    m = 7'h6D;
      4'd6:    m = 7'h7D;
      4'd7:    m = 7'h07;
      4'd8:    m = 7'h7F;
      4'd9:    m = 7'h6F;
      default: m = 7'h40;
    endcase
    return m;
  endfunction

  // With zero blank cycles the ON state chains straight into the next digit,
  // so the frame latch must also be taken on the ON->ON wrap to digit 0.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q + 1'b1;
    idx_d   = idx_q;
    frame_d = frame_q;
    fs_d    = 1'b0;
    unique case (state_q)
      ST_BLANK: begin
        if (BLANK_CYCLES == 0 || timer_q == BLANK_LAST) begin
          state_d = ST_ON;
          timer_d = '0;
          if (idx_q == '0) begin
            frame_d = hold_q;
            fs_d    = 1'b1;
          end
        end
      end
      ST_ON: begin
        if (timer_q == ON_LAST) begin
          timer_d = '0;
          idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
          if (BLANK_CYCLES == 0) begin
            state_d = ST_ON;
            if (idx_d == '0) begin
              frame_d = hold_q;
              fs_d    = 1'b1;
            end
          end else begin
            state_d = ST_BLANK;
          end
        end
      end
    endcase
  end

  always_comb begin
    lz_blank = '0;
`ifdef LEADING_ZERO_BLANK_EN
    begin
      logic        higher_zero;
      int unsigned i;
      higher_zero = 1'b1;
      for (int unsigned k = 0; k < N_DIGITS; k++) begin
        i = N_DIGITS - 1 - k;
        lz_blank[i] = higher_zero && (frame_q[4*i +: 4] == 4'd0) && (i != 0);
        higher_zero = higher_zero && (frame_q[4*i +: 4] == 4'd0);
      end
    end
`endif
  end

  always_comb begin
    nib   = frame_q[4*idx_q +: 4];
    seg_d = 7'h7F;
    en_d  = '1;
    if (state_q == ST_ON) begin
      en_d[idx_q] = 1'b0;
      seg_d       = lz_blank[idx_q] ? 7'h7F : ~seg_mask(nib);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_BLANK;
      timer_q <= '0;
      idx_q   <= '0;
      hold_q  <= '0;
      frame_q <= '0;
      fs_q    <= 1'b0;
      ack_q   <= 1'b0;
      seg_q   <= 7'h7F;
      en_q    <= '1;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      idx_q   <= idx_d;
      frame_q <= frame_d;
      fs_q    <= fs_d;
      ack_q   <= load;
      if (load) hold_q <= bcd_in;
      seg_q   <= seg_d;
      en_q    <= en_d;
    end
  end

  assign load_ack    = ack_q;
  assign seg_n       = seg_q;
  assign digit_en_n  = en_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_bcd_7seg_scan_driver.sv
// Randomised bench for bcd_7seg_scan_driver; expected outputs come from a cycle-count timeline model.
module tb_bcd_7seg_scan_driver;

  localparam int unsigned N   = 4;
  localparam int unsigned DIV = 4;
  localparam int unsigned BLK = 2;
  localparam int unsigned P   = DIV + BLK;
  localparam int unsigned F   = N * P;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        load = 1'b0;
  logic [15:0] bcd_in = '0;
  logic        load_ack;
  logic [6:0]  seg_n;
  logic [3:0]  digit_en_n;
  logic        frame_start;

  always #5 clk = ~clk;

  bcd_7seg_scan_driver #(
    .N_DIGITS    (N),
    .REFRESH_DIV (DIV),
    .BLANK_CYCLES(BLK)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .bcd_in     (bcd_in),
    .load_ack   (load_ack),
    .seg_n      (seg_n),
    .digit_en_n (digit_en_n),
    .frame_start(frame_start)
  );

  int unsigned checks   = 0;
  int unsigned failures = 0;

  // Model state: n = edges since reset release; the display position is pure arithmetic on n.
  int unsigned n = 0;
  logic [15:0] m_hold = '0;
  logic [15:0] m_frame = '0;
  logic        m_ack = 1'b0;
  logic        m_fs = 1'b0;
  logic [6:0]  m_seg = 7'h7F;
  logic [3:0]  m_en = 4'hF;
  logic [6:0]  mask_tab [16];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] expect_seg(input logic [15:0] frame, input int unsigned d);
    logic [15:0] f;
    int unsigned msd;
    f   = frame;
    msd = 0;
    for (int unsigned k = 0; k < N; k++)
      if (f[4*k +: 4] != 4'd0) msd = k;
`ifdef LEADING_ZERO_BLANK_EN
    if (d > msd) return 7'h7F;
`endif
    return ~mask_tab[f[4*d +: 4]];
  endfunction

  task automatic cycle(input logic r, input logic ld, input logic [15:0] v);
    int unsigned slot;
    int unsigned pos;
    reset  = r;
    load   = ld;
    bcd_in = v;
    @(posedge clk);
    if (r) begin
      n = 0; m_hold = '0; m_frame = '0; m_ack = 1'b0; m_fs = 1'b0;
      m_seg = 7'h7F; m_en = 4'hF;
    end else begin
      slot = (n / P) % N;
      pos  = n % P;
      if (pos >= BLK) begin
        m_en  = ~(4'b0001 << slot);
        m_seg = expect_seg(m_frame, slot);
      end else begin
        m_en  = 4'hF;
        m_seg = 7'h7F;
      end
      n++;
      m_fs = (n % F == BLK);
      if (m_fs) m_frame = m_hold;
      m_ack = ld;
      if (ld) m_hold = v;
    end
    #1;
    check_eq("seg_n", 32'(seg_n), 32'(m_seg));
    check_eq("digit_en_n", 32'(digit_en_n), 32'(m_en));
    check_eq("load_ack", 32'(load_ack), 32'(m_ack));
    check_eq("frame_start", 32'(frame_start), 32'(m_fs));
  endtask

  task automatic idle(input int unsigned cnt);
    for (int unsigned i = 0; i < cnt; i++) cycle(1'b0, 1'b0, 16'h0000);
  endtask

  initial begin
    logic [15:0] v;
    logic [15:0] msk;
    int unsigned burst;
    int unsigned guard;
    mask_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                 7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};

    for (int unsigned i = 0; i < 3; i++) cycle(1'b1, 1'b0, 16'h0000);
    idle(2 * F + 5);

    cycle(1'b0, 1'b1, 16'h1234);
    idle(2 * F);
    cycle(1'b0, 1'b1, 16'h12A9);
    idle(2 * F);

    guard = 0;
    while (!m_fs && guard < F + 2) begin
      cycle(1'b0, 1'b0, 16'h0000);
      guard++;
    end
    check_eq("frame_start_found", 32'(m_fs), 32'd1);
    cycle(1'b0, 1'b1, 16'h5678);
    idle(2 * F);

    guard = 0;
    while (m_en != 4'b1011 && guard < F + 2) begin
      cycle(1'b0, 1'b0, 16'h0000);
      guard++;
    end
    cycle(1'b1, 1'b0, 16'h0000);
    idle(F + 8);

    cycle(1'b0, 1'b1, 16'h0007);
    idle(2 * F);
    cycle(1'b0, 1'b1, 16'h0000);
    idle(2 * F);
    cycle(1'b0, 1'b1, 16'h0A00);
    idle(2 * F);

    burst = 0;
    for (int unsigned i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 3))
        0:       msk = 16'hFFFF;
        1:       msk = 16'h00FF;
        2:       msk = 16'h000F;
        default: msk = 16'h0F0F;
      endcase
      v = 16'($urandom) & msk;
      if (burst == 0 && $urandom_range(0, 19) == 0) burst = $urandom_range(1, 4);
      if ($urandom_range(0, 299) == 0) begin
        cycle(1'b1, 1'b0, v);
        burst = 0;
      end else if (burst != 0) begin
        cycle(1'b0, 1'b1, v);
        burst--;
      end else begin
        cycle(1'b0, 1'b0, v);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
